// File: rtl/imm_enc_if.sv
// ============================================================================
// Module   : imm_enc_if
// Purpose  : Field input and encoded-word output bundle for the encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imm_enc_if #(
    parameter int ADDR_W   = 32,
    parameter int ERRCNT_W = 8
);
    logic                valid_i;
    logic                ready_o;
    logic [2:0]          fmt_i;
    logic [6:0]          opcode_i;
    logic [4:0]          rd_i;
    logic [4:0]          rs1_i;
    logic [4:0]          rs2_i;
    logic [2:0]          funct3_i;
    logic [6:0]          funct7_i;
    logic [31:0]         imm_i;
    logic [31:0]         inst_o;
    logic [ADDR_W-1:0]   addr_o;
    logic                out_valid_o;
    logic                out_ready_i;
    logic                err_o;
    logic [ERRCNT_W-1:0] err_cnt_o;

    modport master (
        output valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i,
               funct7_i, imm_i, out_ready_i,
        input  ready_o, inst_o, addr_o, out_valid_o, err_o, err_cnt_o
    );

    modport slave (
        input  valid_i, fmt_i, opcode_i, rd_i, rs1_i, rs2_i, funct3_i,
               funct7_i, imm_i, out_ready_i,
        output ready_o, inst_o, addr_o, out_valid_o, err_o, err_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/imm_enc.sv
// ============================================================================
// Module   : imm_enc
// Purpose  : Packs decoded fields into an RV32I word, range-checks the
//            immediate and emits it with a sequential byte address.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_enc #(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ERRCNT_W  = 8
) (
    input  wire logic  clk_i,
    input  wire logic  rst_ni,
    input  wire logic  clr_i,
    imm_enc_if.slave   bus
);
    // Format codes shared with the decoder; anything else is R-type.
    localparam logic [2:0] c_FMT_I = 3'd1;
    localparam logic [2:0] c_FMT_S = 3'd2;
    localparam logic [2:0] c_FMT_B = 3'd3;
    localparam logic [2:0] c_FMT_U = 3'd4;
    localparam logic [2:0] c_FMT_J = 3'd5;

    localparam logic [ADDR_W-1:0]   c_ADDR_STEP = ADDR_W'(4);
    localparam logic [ERRCNT_W-1:0] c_CNT_MAX   = {ERRCNT_W{1'b1}};

    logic                r_valid;
    logic [31:0]         r_inst;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_err;
    logic [ERRCNT_W-1:0] r_err_cnt;

    logic        w_ready;
    logic        w_accept;
    logic        w_out_hs;
    logic        w_legal;
    logic [31:0] w_enc;

    assign w_ready  = !r_valid || bus.out_ready_i;
    assign w_accept = bus.valid_i && w_ready;
    assign w_out_hs = r_valid && bus.out_ready_i;

    // Legal means the immediate survives the encode/decode round trip.
    always_comb begin
        w_legal = 1'b1;
        w_enc   = {bus.funct7_i, bus.rs2_i, bus.rs1_i, bus.funct3_i,
                   bus.rd_i, bus.opcode_i};
        case (bus.fmt_i)
            c_FMT_I: begin
                w_legal = (bus.imm_i[31:11] == {21{bus.imm_i[11]}});
                w_enc   = {bus.imm_i[11:0], bus.rs1_i, bus.funct3_i,
                           bus.rd_i, bus.opcode_i};
            end
            c_FMT_S: begin
                w_legal = (bus.imm_i[31:11] == {21{bus.imm_i[11]}});
                w_enc   = {bus.imm_i[11:5], bus.rs2_i, bus.rs1_i,
                           bus.funct3_i, bus.imm_i[4:0], bus.opcode_i};
            end
            c_FMT_B: begin
                w_legal = (bus.imm_i[31:12] == {20{bus.imm_i[12]}}) &&
                          !bus.imm_i[0];
                w_enc   = {bus.imm_i[12], bus.imm_i[10:5], bus.rs2_i,
                           bus.rs1_i, bus.funct3_i, bus.imm_i[4:1],
                           bus.imm_i[11], bus.opcode_i};
            end
            c_FMT_U: begin
                w_legal = (bus.imm_i[11:0] == 12'd0);
                w_enc   = {bus.imm_i[31:12], bus.rd_i, bus.opcode_i};
            end
            c_FMT_J: begin
                w_legal = (bus.imm_i[31:20] == {12{bus.imm_i[20]}}) &&
                          !bus.imm_i[0];
                w_enc   = {bus.imm_i[20], bus.imm_i[10:1], bus.imm_i[11],
                           bus.imm_i[19:12], bus.rd_i, bus.opcode_i};
            end
            default: begin
                w_legal = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid   <= 1'b0;
            r_inst    <= 32'd0;
            r_addr    <= BASE_ADDR;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else if (clr_i) begin
            r_valid   <= 1'b0;
            r_addr    <= BASE_ADDR;
            r_err     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_err <= w_accept && !w_legal;
            if (w_accept && !w_legal && (r_err_cnt != c_CNT_MAX)) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
            // The address advances when a word leaves, so the next word
            // loaded in that same edge is tagged with the following slot.
            if (w_out_hs) begin
                r_addr <= r_addr + c_ADDR_STEP;
            end
            if (w_accept && w_legal) begin
                r_valid <= 1'b1;
                r_inst  <= w_enc;
            end else if (w_out_hs) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.ready_o     = w_ready;
    assign bus.inst_o      = r_inst;
    assign bus.addr_o      = r_addr;
    assign bus.out_valid_o = r_valid;
    assign bus.err_o       = r_err;
    assign bus.err_cnt_o   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_imm_enc.sv
// ============================================================================
// Module   : tb_imm_enc
// Purpose  : Self-checking bench: directed cases plus random round trips
//            against a behavioural legality / immediate-decode model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_enc;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [2:0]  F_R = 3'd0, F_I = 3'd1, F_S = 3'd2,
                            F_B = 3'd3, F_U = 3'd4, F_J = 3'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr = 1'b0;

    imm_enc_if #(.ADDR_W(32), .ERRCNT_W(8)) bus ();

    imm_enc #(.ADDR_W(32), .BASE_ADDR(BASE), .ERRCNT_W(8)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .clr_i  (clr),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_addr;
    bit          m_err;
    int          m_cnt;
    logic [2:0]  m_fmt;
    logic [6:0]  m_op, m_f7;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [2:0]  m_f3;
    logic [31:0] m_imm;
    int          n_legal;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic bit imm_legal(input logic [2:0] f, input logic [31:0] imm);
        int s;
        s = $signed(imm);
        case (f)
            F_I, F_S: return (s >= -2048) && (s <= 2047);
            F_B:      return (s >= -4096) && (s <= 4095) && (imm[0] == 1'b0);
            F_J:      return (s >= -(1 << 20)) && (s < (1 << 20)) && (imm[0] == 1'b0);
            F_U:      return (imm % 4096) == 0;
            default:  return 1'b1;
        endcase
    endfunction

    // Standard RV32I immediate generator
    function automatic logic [31:0] imm_gen(input logic [31:0] i, input logic [2:0] f);
        case (f)
            F_I:     return {{20{i[31]}}, i[31:20]};
            F_S:     return {{20{i[31]}}, i[31:25], i[11:7]};
            F_B:     return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            F_U:     return {i[31:12], 12'd0};
            F_J:     return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: return 32'd0;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [2:0] f, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] imm);
        bus.valid_i  = v;
        bus.fmt_i    = f;
        bus.opcode_i = op;
        bus.rd_i     = rd;
        bus.rs1_i    = rs1;
        bus.rs2_i    = rs2;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
        bus.imm_i    = imm;
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_addr  = BASE;
        m_err   = 1'b0;
        m_cnt   = 0;
    endtask

    // Called just after a negedge with inputs set; advances one clock.
    task automatic step();
        bit acc, legal, hs;
        #1;
        check_eq("ready", 32'(bus.ready_o), 32'(!m_valid || bus.out_ready_i));
        acc   = bus.valid_i && (!m_valid || bus.out_ready_i);
        legal = imm_legal(bus.fmt_i, bus.imm_i);
        hs    = m_valid && bus.out_ready_i;
        if (clr) begin
            model_reset();
        end else begin
            if (hs) m_addr = m_addr + 32'd4;
            m_err = acc && !legal;
            if (acc && !legal && m_cnt < 255) m_cnt++;
            if (acc && legal) begin
                m_valid = 1'b1;
                m_fmt = bus.fmt_i;  m_op = bus.opcode_i; m_rd = bus.rd_i;
                m_rs1 = bus.rs1_i;  m_rs2 = bus.rs2_i;  m_f3 = bus.funct3_i;
                m_f7 = bus.funct7_i; m_imm = bus.imm_i;
                if (bus.fmt_i inside {F_I, F_S, F_B, F_U, F_J}) n_legal++;
            end else if (hs) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("out_valid", 32'(bus.out_valid_o), 32'(m_valid));
        check_eq("addr", bus.addr_o, m_addr);
        check_eq("err", 32'(bus.err_o), 32'(m_err));
        check_eq("err_cnt", 32'(bus.err_cnt_o), 32'(m_cnt));
        if (m_valid) begin
            check_eq("opcode", 32'(bus.inst_o[6:0]), 32'(m_op));
            case (m_fmt)
                F_I: begin
                    check_eq("rd", 32'(bus.inst_o[11:7]), 32'(m_rd));
                    check_eq("rs1", 32'(bus.inst_o[19:15]), 32'(m_rs1));
                    check_eq("f3", 32'(bus.inst_o[14:12]), 32'(m_f3));
                    check_eq("imm_rt", imm_gen(bus.inst_o, m_fmt), m_imm);
                end
                F_S, F_B: begin
                    check_eq("rs1", 32'(bus.inst_o[19:15]), 32'(m_rs1));
                    check_eq("rs2", 32'(bus.inst_o[24:20]), 32'(m_rs2));
                    check_eq("f3", 32'(bus.inst_o[14:12]), 32'(m_f3));
                    check_eq("imm_rt", imm_gen(bus.inst_o, m_fmt), m_imm);
                end
                F_U, F_J: begin
                    check_eq("rd", 32'(bus.inst_o[11:7]), 32'(m_rd));
                    check_eq("imm_rt", imm_gen(bus.inst_o, m_fmt), m_imm);
                end
                default: begin
                    check_eq("r_word", bus.inst_o,
                             {m_f7, m_rs2, m_rs1, m_f3, m_rd, m_op});
                end
            endcase
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] imm;
        int          iter;

        drive(0, F_R, 0, 0, 0, 0, 0, 0, 0);
        bus.out_ready_i = 1'b1;
        model_reset();
        n_legal = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("rst_inst", bus.inst_o, 32'd0);
        check_eq("rst_addr", bus.addr_o, BASE);
        check_eq("rst_err", 32'(bus.err_o), 32'd0);
        check_eq("rst_cnt", 32'(bus.err_cnt_o), 32'd0);
        rst_n = 1'b1;

        // Directed encodings, back to back
        drive(1, F_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
        step();
        check_eq("t1_inst", bus.inst_o, 32'hFFF0_0093);
        check_eq("t1_addr", bus.addr_o, BASE);
        drive(1, F_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        step();
        check_eq("s_inst", bus.inst_o, 32'h0020_A423);
        check_eq("s_addr", bus.addr_o, BASE + 32'd4);
        drive(1, F_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
        step();
        check_eq("b_inst", bus.inst_o, 32'hFE00_0EE3);
        drive(1, F_J, 7'b1101111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8);
        step();
        check_eq("j_inst", bus.inst_o, 32'h0080_006F);
        drive(1, F_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
        step();
        check_eq("u_inst", bus.inst_o, 32'h1234_52B7);
        check_eq("u_addr", bus.addr_o, BASE + 32'd16);
        drive(0, F_R, 0, 0, 0, 0, 0, 0, 0);
        step();

        // Illegal immediates
        drive(1, F_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        step();
        check_eq("ill_i_cnt", 32'(bus.err_cnt_o), 32'd1);
        check_eq("ill_i_err", 32'(bus.err_o), 32'd1);
        drive(0, F_R, 0, 0, 0, 0, 0, 0, 0);
        step();
        drive(1, F_B, 7'b1100011, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
        step();
        check_eq("ill_b_cnt", 32'(bus.err_cnt_o), 32'd2);
        drive(1, F_U, 7'b0110111, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001);
        step();
        check_eq("ill_u_cnt", 32'(bus.err_cnt_o), 32'd3);
        check_eq("ill_addr", bus.addr_o, BASE + 32'd20);

        // Backpressure
        bus.out_ready_i = 1'b0;
        drive(1, F_I, 7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
        step();
        drive(1, F_S, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
        repeat (5) begin
            step();
            check_eq("stall_inst", bus.inst_o, 32'h0050_0193);
            check_eq("stall_ready", 32'(bus.ready_o), 32'd0);
        end
        bus.out_ready_i = 1'b1;
        step();
        check_eq("release_inst", bus.inst_o, 32'h0020_A423);
        check_eq("release_addr", bus.addr_o, BASE + 32'd24);

        // Clear wins over an input offered in the same cycle
        bus.out_ready_i = 1'b0;
        clr = 1'b1;
        drive(1, F_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
        step();
        clr = 1'b0;
        check_eq("clr_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("clr_addr", bus.addr_o, BASE);
        check_eq("clr_cnt", 32'(bus.err_cnt_o), 32'd0);

        // Error counter saturation
        bus.out_ready_i = 1'b1;
        drive(1, F_I, 7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4096);
        repeat (300) step();
        check_eq("sat_cnt", 32'(bus.err_cnt_o), 32'd255);

        // Random round trip
        iter = 0;
        while (n_legal < 10000 && iter < 40000) begin
            f = 3'($urandom_range(0, 7));
            case (f)
                F_I, F_S: imm = 32'($urandom_range(0, 4095)) - 32'd2048;
                F_B:      imm = (32'($urandom_range(0, 8191)) - 32'd4096) << 1 >> 1 << 0;
                F_U:      imm = $urandom & 32'hFFFF_F000;
                F_J:      imm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000);
                default:  imm = $urandom;
            endcase
            if (f == F_B || f == F_J) imm[0] = 1'b0;
            if ($urandom_range(0, 15) == 0) imm = $urandom;
            drive($urandom_range(0, 4) != 0, f, 7'($urandom), 5'($urandom),
                  5'($urandom), 5'($urandom), 3'($urandom), 7'($urandom), imm);
            bus.out_ready_i = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 499) == 0);
            step();
            iter++;
        end
        clr = 1'b0;
        check_eq("rand_legal_10k", 32'(n_legal >= 10000), 32'd1);

        // Asynchronous reset while a word is stalled
        bus.out_ready_i = 1'b1;
        drive(0, F_R, 0, 0, 0, 0, 0, 0, 0);
        step();
        bus.out_ready_i = 1'b0;
        drive(1, F_I, 7'b0010011, 5'd2, 5'd3, 5'd0, 3'd1, 7'd0, 32'd7);
        step();
        step();
        check_eq("pre_rst_valid", 32'(bus.out_valid_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("arst_valid", 32'(bus.out_valid_o), 32'd0);
        check_eq("arst_inst", bus.inst_o, 32'd0);
        check_eq("arst_addr", bus.addr_o, BASE);
        check_eq("arst_err", 32'(bus.err_o), 32'd0);
        check_eq("arst_cnt", 32'(bus.err_cnt_o), 32'd0);
        @(negedge clk);
        drive(0, F_R, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/imm_enc.md
Name: imm_enc

Overview:
Instruction encoder: the inverse of the immediate generator. Accepts decoded fields (format, opcode, registers, functs, 32-bit immediate) and packs them into a 32-bit RV32I instruction word. Range-checks the immediate, registers the result behind a valid/ready handshake, and tags each emitted word with a sequential instruction-memory byte address. Used by the program loader and by the self-check bench for round-trip checks against the immediate generator.

Parameters:
BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word and restored by clr_i
ADDR_W, 32, width of addr_o; the address wraps modulo 2^ADDR_W
ERRCNT_W, 8, width of err_cnt_o; the count saturates

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
clr_i  input  1  synchronous clear: drops the output word, resets addr_o and err_cnt_o
valid_i  input  1  input fields valid
ready_o  output  1  encoder can accept this cycle
fmt_i  input  3  format; uses the define.sv codes `I_TYPE/`S_TYPE/`B_TYPE/`J_TYPE/`U_TYPE; any other code encodes as R-type
opcode_i  input  7  inst[6:0]
rd_i  input  5  destination register
rs1_i  input  5  source 1
rs2_i  input  5  source 2
funct3_i  input  3  funct3
funct7_i  input  7  funct7 (R-type only)
imm_i  input  32  sign-extended immediate value
inst_o  output  32  encoded instruction
addr_o  output  ADDR_W  byte address of inst_o
out_valid_o  output  1  inst_o/addr_o valid
out_ready_i  input  1  downstream accepts
err_o  output  1  one-cycle pulse: the last accepted input had an unencodable immediate
err_cnt_o  output  ERRCNT_W  saturating count of rejected inputs

Behaviour:
- Reset (rst_ni=0, async): out_valid_o=0, inst_o=0, addr_o=BASE_ADDR, err_o=0, err_cnt_o=0.
- ready_o = !out_valid_o || out_ready_i. This is combinational. An input is accepted when valid_i && ready_o.
- Encoding of an accepted input is registered with 1-cycle latency into inst_o. Packing by format:
  - R: funct7|rs2|rs1|funct3|rd|opcode
  - I: imm[11:0]|rs1|funct3|rd|opcode
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode
  - U: imm[31:12]|rd|opcode
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode
- Legality rules (R-type ignores imm_i and never errors):
  - I/S: imm_i must be the sign-extension of imm[11:0].
  - B: the sign-extension of imm[12:0], with imm[0]=0.
  - J: the sign-extension of imm[20:0], with imm[0]=0.
  - U: imm[11:0]=0.
- Illegal accepted input:
  - The word is dropped: out_valid_o is not set by it, and inst_o and addr_o hold.
  - err_o=1 on the next cycle only; err_cnt_o increments and saturates at all-ones.
  - Acceptance still consumes the input.
- Legal accepted input: the next cycle gives out_valid_o=1 and inst_o=the encoding. Any prior word leaves in the same cycle via out_ready_i.
- Output handshake: on out_valid_o && out_ready_i, addr_o += 4 (wrapping) at that edge. If no new legal word loads, out_valid_o drops to 0.
- Stall: out_valid_o=1 && out_ready_i=0 → inst_o and addr_o hold stable and ready_o=0.
- Invariant: for every emitted legal word, imm_gen(inst_o[31:7], fmt) == imm_i (U/I/S/B/J).
- clr_i=1 has priority over everything except reset, at the clock edge:
  - out_valid_o=0, addr_o=BASE_ADDR, err_cnt_o=0, err_o=0.
  - Inputs presented that cycle are discarded even if ready_o=1.
  - ready_o is not gated by clr_i.
- A reset asserted mid-stall discards the held word; no partial output.

Test Plan:
1. Reset, then I-type, opcode 0010011, rd=1, rs1=0, f3=0, imm=32'hFFFF_FFFF, out_ready_i=1 → 1 cycle later out_valid_o=1, inst_o=32'hFFF0_0093, addr_o=BASE_ADDR; next word gets addr_o=BASE_ADDR+4.
2. Back-to-back, out_ready_i=1:
   - S: opcode 0100011, f3=2, rs1=1, rs2=2, imm=8 → 32'h0020_A423.
   - B: opcode 1100011, rs1=rs2=0, f3=0, imm=-4 → 32'hFE00_0EE3.
   - J: opcode 1101111, rd=0, imm=8 → 32'h0080_006F.
   - U: opcode 0110111, rd=5, imm=32'h1234_5000 → 32'h1234_52B7.
   - Addresses are consecutive +4; ready_o is held at 1 throughout.
3. Illegal immediates:
   - I-type imm=2048 → no out_valid_o, err_o pulses 1 cycle, err_cnt_o=1.
   - B-type imm=3 (odd) → err_cnt_o=2.
   - U-type imm=32'h0000_0001 → err_cnt_o=3.
   - addr_o is unchanged across all three.
4. Backpressure: hold out_ready_i=0 with a valid word → ready_o=0, inst_o/addr_o stable for 5 cycles. Release → handshake, addr_o+=4, and a waiting input is accepted the same cycle.
5. Drive clr_i together with valid_i=1 while out_valid_o=1 → next cycle out_valid_o=0, addr_o=BASE_ADDR, err_cnt_o=0, and the input is lost. Drive 256+ illegal inputs (ERRCNT_W=8) → err_cnt_o saturates at 255.
6. Random round-trip, ≥10k legal vectors: the imm_gen output on inst_o equals imm_i. Assert rst_ni low mid-stall → outputs take their reset values immediately (async).
